// File: rtl/prng_pkg.sv
// Shared types and constants for the ranged PRNG: FSM states, the table of
// maximal-length LFSR tap masks and the bit-smear helper used to build range masks.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } prng_state_e;

  // Index = LFSR width; bit i set means state[i] feeds the XOR. Entries 0..3 unused.
  localparam logic [31:0] LFSR_TAPS [33] = '{
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
    32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
    32'h0000_0E08, 32'h0000_1C80, 32'h0000_3802, 32'h0000_6000,
    32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0007_2000,
    32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
    32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
    32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
    32'h8020_0003
  };

  // Smallest 2^k-1 that is >= v.
  function automatic logic [31:0] mask_smear(input logic [31:0] v);
    logic [31:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with runtime seed load and recovery from the all-zero state.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int unsigned    N    = 16,
  parameter logic [N-1:0]   TAPS = N'(LFSR_TAPS[N]),
  parameter logic [N-1:0]   SEED = N'(31)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         step,
  output logic [N-1:0] state
);

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? SEED : seed;
    end else if (step) begin
      state_d = (state_q == '0) ? SEED : {state_q[N-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/prng_range.sv
// Request/ack generator returning a uniform value in [0, iRange) by bounded
// rejection sampling over a free-running LFSR.
module prng_range
  import prng_pkg::*;
#(
  parameter int unsigned  N         = 16,
  parameter logic [N-1:0] TAPS      = N'(LFSR_TAPS[N]),
  parameter logic [N-1:0] SEED      = N'(31),
  parameter int unsigned  OUT_W     = 10,
  parameter int unsigned  MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             iResetN,
  input  logic             iEnable,
  input  logic             iSeedLoad,
  input  logic [N-1:0]     iSeed,
  input  logic             iReq,
  input  logic [OUT_W-1:0] iRange,
  input  logic             iAck,
  output logic             oValid,
  output logic [OUT_W-1:0] oValue,
  output logic             oBusy,
  output logic [N-1:0]     oState
);

  localparam int unsigned TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  prng_state_e        fsm_q,      fsm_d;
  logic [OUT_W-1:0]   range_q,    range_d;
  logic [OUT_W-1:0]   mask_q,     mask_d;
  logic [TRIES_W-1:0] tries_q,    tries_d;
  logic [OUT_W-1:0]   cand_q,     cand_d;
  logic               cand_vld_q, cand_vld_d;
  logic               valid_q,    valid_d;
  logic [OUT_W-1:0]   value_q,    value_d;
  logic [OUT_W-1:0]   range_new;
  logic [N-1:0]       lfsr_state;
  logic               lfsr_step;

  assign lfsr_step = iEnable | (fsm_q == GEN);

  lfsr_core #(
    .N   (N),
    .TAPS(TAPS),
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(iResetN),
    .load (iSeedLoad),
    .seed (iSeed),
    .step (lfsr_step),
    .state(lfsr_state)
  );

  // Candidates are captured from the pre-step state one cycle and judged the
  // next, so the first verdict lands two edges after the request is accepted.
  always_comb begin
    fsm_d      = fsm_q;
    range_d    = range_q;
    mask_d     = mask_q;
    tries_d    = tries_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    valid_d    = valid_q;
    value_d    = value_q;
    range_new  = (iRange == '0) ? OUT_W'(1) : iRange;
    if (iSeedLoad) begin
      fsm_d      = IDLE;
      valid_d    = 1'b0;
      tries_d    = '0;
      cand_vld_d = 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (iReq) begin
            range_d    = range_new;
            mask_d     = OUT_W'(mask_smear(32'(range_new - OUT_W'(1))));
            tries_d    = '0;
            cand_vld_d = 1'b0;
            fsm_d      = GEN;
          end
        end
        GEN: begin
          cand_d     = lfsr_state[OUT_W-1:0] & mask_q;
          cand_vld_d = 1'b1;
          if (cand_vld_q) begin
            if (cand_q < range_q) begin
              value_d    = cand_q;
              valid_d    = 1'b1;
              cand_vld_d = 1'b0;
              fsm_d      = DONE;
            end else if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
              value_d    = cand_q - range_q;
              valid_d    = 1'b1;
              cand_vld_d = 1'b0;
              fsm_d      = DONE;
            end else begin
              tries_d = tries_q + TRIES_W'(1);
            end
          end
        end
        DONE: begin
          if (iAck) begin
            valid_d = 1'b0;
            fsm_d   = IDLE;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!iResetN) begin
      fsm_q      <= IDLE;
      range_q    <= '0;
      mask_q     <= '0;
      tries_q    <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      value_q    <= '0;
    end else begin
      fsm_q      <= fsm_d;
      range_q    <= range_d;
      mask_q     <= mask_d;
      tries_q    <= tries_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      valid_q    <= valid_d;
      value_q    <= value_d;
    end
  end

  assign oValid = valid_q;
  assign oValue = value_q;
  assign oBusy  = (fsm_q != IDLE);
  assign oState = lfsr_state;

endmodule

// File: tb/tb_prng_range.sv
// Self-checking bench for prng_range: directed vectors, corner sequences and
// randomized requests checked against a plain-arithmetic reference model.
module tb_prng_range;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, sl, req, ack;
  logic [15:0] seed;
  logic [9:0]  rng;
  logic        vA, bA, vB, bB, vC, bC;
  logic [9:0]  valA, valB;
  logic [15:0] stA, stB;
  logic [3:0]  valC, stC;
  logic [3:0]  seedC = 4'h0;
  logic [3:0]  rngC  = 4'h0;
  logic        zero1 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] mA, mB;

  prng_range #(.N(16), .TAPS(16'hD008), .SEED(16'd31), .OUT_W(10), .MAX_TRIES(8)) dut_a (
    .clk(clk), .iResetN(rst_n), .iEnable(en), .iSeedLoad(sl), .iSeed(seed),
    .iReq(req), .iRange(rng), .iAck(ack),
    .oValid(vA), .oValue(valA), .oBusy(bA), .oState(stA));

  prng_range #(.N(16), .TAPS(16'hD008), .SEED(16'd31), .OUT_W(10), .MAX_TRIES(1)) dut_b (
    .clk(clk), .iResetN(rst_n), .iEnable(en), .iSeedLoad(sl), .iSeed(seed),
    .iReq(req), .iRange(rng), .iAck(ack),
    .oValid(vB), .oValue(valB), .oBusy(bB), .oState(stB));

  prng_range #(.N(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4), .MAX_TRIES(8)) dut_c (
    .clk(clk), .iResetN(rst_n), .iEnable(en), .iSeedLoad(zero1), .iSeed(seedC),
    .iReq(zero1), .iRange(rngC), .iAck(zero1),
    .oValid(vC), .oValue(valC), .oBusy(bC), .oState(stC));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: polynomial step as parity of tapped bits.
  function automatic logic [15:0] nxt16(input logic [15:0] s);
    logic fb;
    if (s == 16'h0) return 16'd31;
    fb = ($countones(s & 16'hD008) % 2) == 1;
    return {s[14:0], fb};
  endfunction

  // Candidate k is drawn from the state k steps after acceptance and is
  // reported two edges later.
  function automatic void predict(input logic [15:0] s0, input int r, input int maxt,
                                  output int val, output int lat);
    int rr, m, c;
    logic [15:0] s;
    rr = (r == 0) ? 1 : r;
    m  = 0;
    while (m < rr - 1) m = m * 2 + 1;
    s   = s0;
    val = -1;
    lat = -1;
    for (int k = 0; k < maxt; k++) begin
      c = int'(s[9:0]) & m;
      if (c < rr) begin val = c; lat = k + 2; return; end
      if (k == maxt - 1) begin val = c - rr; lat = k + 2; return; end
      s = nxt16(s);
    end
  endfunction

  task automatic load_seed(input logic [15:0] sv);
    sl = 1'b1; seed = sv;
    tick();
    sl = 1'b0;
    mA = (sv == 16'h0) ? 16'd31 : sv;
    mB = mA;
    chk("seed_state_a", 32'(stA), 32'(mA));
    chk("seed_state_b", 32'(stB), 32'(mB));
    chk("seed_idle_a", 32'(bA), 0);
  endtask

  task automatic run_req(input logic [9:0] r, input bit do_ack, input string tag,
                         input int eva, input int ela, input int evb, input int elb);
    int la, lb, e;
    logic [9:0] ga, gb;
    req = 1'b1; rng = r;
    tick();
    req = 1'b0;
    chk({tag, "_busy_a"}, 32'(bA), 1);
    la = 0; lb = 0; ga = '0; gb = '0; e = 0;
    while ((la == 0 || lb == 0) && e < 20) begin
      tick();
      e++;
      if (vA && la == 0) begin la = e; ga = valA; end
      if (vB && lb == 0) begin lb = e; gb = valB; end
    end
    chk({tag, "_lat_a"}, la, ela);
    chk({tag, "_val_a"}, 32'(ga), eva);
    chk({tag, "_lat_b"}, lb, elb);
    chk({tag, "_val_b"}, 32'(gb), evb);
    for (int i = 0; i < ela; i++) mA = nxt16(mA);
    for (int i = 0; i < elb; i++) mB = nxt16(mB);
    tick();
    chk({tag, "_hold_v"}, 32'(vA), 1);
    chk({tag, "_hold_val"}, 32'(valA), eva);
    chk({tag, "_state_a"}, 32'(stA), 32'(mA));
    chk({tag, "_state_b"}, 32'(stB), 32'(mB));
    if (do_ack) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk({tag, "_ack_v"}, 32'(vA), 0);
      chk({tag, "_ack_busy"}, 32'(bA), 0);
      chk({tag, "_ack_val"}, 32'(valA), eva);
      chk({tag, "_ack_vb"}, 32'(vB), 0);
    end
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [9:0]  rng;
    int va; int la; int vb; int lb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ret, zero_seen, nen, r, eva, ela, evb, elb;
    logic [15:0] seen, sv;

    tbl[0] = '{16'h0005, 10'd6,  5, 2, 5, 2};
    tbl[1] = '{16'h0003, 10'd3,  2, 3, 0, 2};
    tbl[2] = '{16'h1234, 10'd0,  0, 2, 0, 2};
    tbl[3] = '{16'h00FF, 10'd1,  0, 2, 0, 2};
    tbl[4] = '{16'h0000, 10'd16, 15, 2, 15, 2};
    tbl[5] = '{16'h0007, 10'd5,  3, 5, 2, 2};

    rst_n = 1'b0; en = 1'b0; sl = 1'b0; req = 1'b0; ack = 1'b0; seed = '0; rng = '0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_state", 32'(stA), 32'h1F);
    chk("rst_valid", 32'(vA), 0);
    chk("rst_value", 32'(valA), 0);
    chk("rst_busy", 32'(bA), 0);
    chk("rst_state_c", 32'(stC), 1);
    chk("rst_c_out", {vC, bC, valC}, 0);

    mA = 16'h1F;
    first_ret = 0; zero_seen = 0; seen = '0;
    en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      mA = nxt16(mA);
      if (i == 1) begin
        chk("step1_state", 32'(stA), 32'h3F);
        chk("step1_valid", 32'(vA), 0);
        chk("step1_value", 32'(valA), 0);
      end
      if (stC == 4'h0) zero_seen++;
      seen[stC] = 1'b1;
      if (stC == 4'h1 && first_ret == 0) first_ret = i;
    end
    en = 1'b0;
    chk("c_period", first_ret, 15);
    chk("c_zero", zero_seen, 0);
    chk("c_distinct", $countones(seen), 15);
    chk("free_run_a", 32'(stA), 32'(mA));

    for (int i = 0; i < 6; i++) begin
      load_seed(tbl[i].seed);
      run_req(tbl[i].rng, 1'b1, $sformatf("vec%0d", i),
              tbl[i].va, tbl[i].la, tbl[i].vb, tbl[i].lb);
    end

    // Seed load while generating drops the request.
    load_seed(16'h0007);
    req = 1'b1; rng = 10'd5;
    tick();
    req = 1'b0;
    tick();
    sl = 1'b1; seed = 16'h0ABC;
    tick();
    sl = 1'b0;
    chk("sl_gen_valid", 32'(vA), 0);
    chk("sl_gen_busy", 32'(bA), 0);
    chk("sl_gen_state", 32'(stA), 32'h0ABC);
    chk("sl_gen_busy_b", 32'(bB), 0);
    repeat (4) tick();
    chk("sl_gen_stay", {vA, bA, vB, bB}, 0);
    mA = 16'h0ABC; mB = 16'h0ABC;

    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle", {vA, bA}, 0);
    chk("ack_idle_state", 32'(stA), 32'(mA));

    // Request pulsed while a result waits for acknowledgement.
    load_seed(16'h0005);
    run_req(10'd6, 1'b0, "done_req", 5, 2, 5, 2);
    req = 1'b1; rng = 10'd1;
    tick();
    req = 1'b0;
    tick();
    chk("done_req_v", 32'(vA), 1);
    chk("done_req_val", 32'(valA), 5);
    chk("done_req_busy", 32'(bA), 1);
    chk("done_req_state", 32'(stA), 32'(mA));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("done_req_ack", 32'(vA), 0);

    // Reset in the middle of generation.
    load_seed(16'h0007);
    req = 1'b1; rng = 10'd5;
    tick();
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_gen_state", 32'(stA), 32'h1F);
    chk("rst_gen_out", {vA, bA}, 0);
    chk("rst_gen_value", 32'(valA), 0);
    chk("rst_gen_state_b", 32'(stB), 32'h1F);
    mA = 16'h1F; mB = 16'h1F;

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        sv = ($urandom_range(3, 0) == 0) ? 16'h0 : 16'($urandom);
        load_seed(sv);
      end
      nen = $urandom_range(3, 0);
      if (nen > 0) begin
        en = 1'b1;
        repeat (nen) begin
          tick();
          mA = nxt16(mA);
          mB = nxt16(mB);
        end
        en = 1'b0;
      end
      case ($urandom_range(3, 0))
        0:       r = $urandom_range(1, 0);
        1:       r = $urandom_range(20, 2);
        2:       r = (1 << $urandom_range(9, 1)) + 1;
        default: r = $urandom_range(1023, 0);
      endcase
      predict(mA, r, 8, eva, ela);
      predict(mB, r, 1, evb, elb);
      run_req(10'(r), 1'b1, $sformatf("rnd%0d", it), eva, ela, evb, elb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prng_range.md
Name: prng_range

Overview:
- Parametrised successor to the 8-bit Fibonacci LFSR.
- Generalised width and tap mask, runtime seed load, all-zero lockup recovery.
- Adds a request/ack generator returning a uniform value in [0, iRange) via bounded rejection sampling.
- Feeds the reaction-time test with random delays and target positions, replacing ad-hoc modulo of raw LFSR bits.

Parameters:
- N, 16: LFSR width; legal 4..32.
- TAPS, 16'hD008: feedback mask (bit i set = state[i] feeds XOR); default x^16+x^15+x^13+x^4+1, maximal length.
- SEED, 31: reset and zero-recovery state; must be nonzero.
- OUT_W, 10: width of iRange/oValue; must be <= N.
- MAX_TRIES, 8: rejection attempts before fallback; >= 1.

Ports:
- clk  in  1  system clock
- iResetN  in  1  synchronous active-low reset
- iEnable  in  1  free-run: advance LFSR one step per cycle while high
- iSeedLoad  in  1  load iSeed into LFSR this cycle (highest priority after reset)
- iSeed  in  N  seed value; 0 substituted by SEED
- iReq  in  1  request one ranged value (sampled only in IDLE)
- iRange  in  OUT_W  exclusive upper bound, latched on accept; 0 treated as 1
- iAck  in  1  consumer accepts oValue
- oValid  out  1  oValue holds a result
- oValue  out  OUT_W  ranged random result
- oBusy  out  1  FSM not in IDLE
- oState  out  N  raw LFSR state

Behaviour:
- One clock, synchronous active-low reset: reset takes effect at the posedge where iResetN=0.
- Reset values: LFSR=SEED, FSM=IDLE, oValid=0, oValue=0, tries=0, oBusy=0.
- LFSR step: fb = ^(state & TAPS); next = {state[N-2:0], fb}.
- If state==0 (only reachable with a bad TAPS), next = SEED.
- LFSR update priority: reset > iSeedLoad (state = iSeed, or SEED if iSeed==0) > step when (iEnable | FSM==GEN) > hold.
- iSeedLoad also forces FSM to IDLE, clears oValid and tries; in-flight request is dropped.
- FSM states IDLE, GEN, DONE. oBusy = (FSM != IDLE).
- IDLE: iReq=1 and iSeedLoad=0 at an edge: latch rRange = max(iRange,1); rMask = all-ones smear of (rRange-1), i.e. smallest 2^k-1 >= rRange-1; tries=0; go GEN.
- iReq in GEN or DONE is ignored (no queuing).
- GEN, each cycle: cand = state[OUT_W-1:0] & rMask, from the pre-step state; LFSR steps the same edge.
  - cand < rRange: oValue=cand, oValid=1, go DONE.
  - else if tries == MAX_TRIES-1: oValue = cand - rRange (always < rRange since cand < 2*rRange), oValid=1, go DONE.
  - else tries++, stay in GEN.
- Latency: req accepted at edge t; earliest oValid=1 after edge t+2; worst case after edge t+1+MAX_TRIES.
- DONE: oValid and oValue held stable until iAck=1 at an edge; then oValid=0, go IDLE.
  - oValue keeps its last value.
  - iAck outside DONE has no effect.
- rRange==1: mask=0, cand=0, accepted in the first GEN cycle.
- Arithmetic is unsigned. Comparison and subtraction are OUT_W wide.

Decomposition:
- Package prng_pkg holds:
  - FSM state enum (IDLE/GEN/DONE);
  - localparam table of maximal-length tap masks for N=4..32, e.g. N=4 -> 4'hC, N=8 -> 8'hB8, N=16 -> 16'hD008;
  - function mask_smear(OUT_W).
- Sub-module lfsr_core (N, TAPS, SEED) owns the LFSR state, zero-recovery and seed load, with a step input.
- prng_range holds the FSM, range latch and output registers.

Test Plan:
- Reset, then one cycle iEnable=1 -> oState 0x001F before the step, 0x003F after; oValid=0, oValue=0.
- N=4, TAPS=4'hC, SEED=1, iEnable held -> oState period exactly 15, never 0, returns to 0x1.
- iSeedLoad with iSeed=0x0005, then iReq with iRange=6 -> oValue=5 with oValid=1 two edges after accept; held until iAck; oValid=0 after the iAck edge.
- Seed 0x0003, iRange=3 -> first cand 3 rejected, state steps to 0x0006, cand 2 accepted; oValid three edges after accept, oValue=2.
  - Same stimulus with MAX_TRIES=1 -> oValue=0 (fallback 3-3) two edges after accept.
- iRange=0 and iRange=1 -> oValue=0.
- iSeedLoad asserted while in GEN -> FSM IDLE, oValid stays 0, oState=iSeed next cycle.
- iReq pulsed in DONE -> ignored, oValue unchanged.
- iResetN=0 mid-GEN -> all reset values next cycle.
